// File: rtl/cpu_pkg.sv
// cpu_pkg: shared arbiter state encodings and memory direction constants
package cpu_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_t;
  localparam logic MEM_RW_READ  = 1'b1;
  localparam logic MEM_RW_WRITE = 1'b0;
endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: 4-bit wait-state counter with clear, increment and terminal-count compare
module mem_wait_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic [3:0] limit,
  output logic       tc
);
  logic [3:0] count;
  // counts access cycles; held at zero while the bus is idle
  always_ff @(posedge clock or posedge reset)
    if (reset) count <= '0;
    else count <= clear ? 4'd0 : en ? count + 4'd1 : count;
  assign tc = count == limit;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of one wait-stated memory port between cpu and DMA
module mem_bus_arbiter
  import cpu_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_datao,
  output logic          mem_rw,
  input  logic [DW-1:0] mem_data,
  output logic          busy
);
  arb_state_t state;
  logic owner, rr_ptr, gnt, tc;
  // on conflict the round-robin pointer picks, otherwise the lone requester wins
  always_comb gnt = (req0 & req1) ? rr_ptr : req1;
  mem_wait_counter u_wait (
    .clock(clock),
    .reset(reset),
    .clear(state == ARB_IDLE),
    .en   (state == ARB_ACCESS),
    .limit(4'(WAIT_CYCLES)),
    .tc   (tc)
  );
  // access sequencer: grant in IDLE, hold bus through the wait window, ack in DONE
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state       <= ARB_IDLE;
      owner       <= 1'b0;
      rr_ptr      <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      mem_address <= '0;
      mem_datao   <= '0;
      mem_rw      <= MEM_RW_READ;
      busy        <= 1'b0;
    end else
      case (state)
        ARB_IDLE:
          if (req0 | req1) begin
            owner       <= gnt;
            mem_address <= gnt ? addr1 : addr0;
            mem_datao   <= gnt ? wdata1 : wdata0;
            mem_rw      <= (gnt ? we1 : we0) ? MEM_RW_WRITE : MEM_RW_READ;
            busy        <= 1'b1;
            state       <= ARB_ACCESS;
          end
        ARB_ACCESS:
          if (tc) begin
            if (mem_rw == MEM_RW_READ && !owner) rdata0 <= mem_data;
            if (mem_rw == MEM_RW_READ && owner) rdata1 <= mem_data;
            ack0        <= ~owner;
            ack1        <= owner;
            rr_ptr      <= ~owner;
            mem_address <= '0;
            mem_datao   <= '0;
            mem_rw      <= MEM_RW_READ;
            state       <= ARB_DONE;
          end
        ARB_DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized checks of the two-port memory arbiter
module tb_mem_bus_arbiter;
  localparam int W = 2;
  logic clock, reset, req0, we0, req1, we1, ack0, ack1, mem_rw, busy;
  logic [31:0] addr0, wdata0, addr1, wdata1, mem_data, rdata0, rdata1, mem_address, mem_datao;
  logic ack0_z, ack1_z, mrw_z, busy_z;
  logic [31:0] rdata0_z, rdata1_z, maddr_z, mdo_z;
  int n_cmp, n_err;

  mem_bus_arbiter #(.WAIT_CYCLES(W)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_address(mem_address), .mem_datao(mem_datao), .mem_rw(mem_rw), .mem_data(mem_data),
    .busy(busy)
  );

  mem_bus_arbiter #(.WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0_z), .rdata0(rdata0_z),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1_z), .rdata1(rdata1_z),
    .mem_address(maddr_z), .mem_datao(mdo_z), .mem_rw(mrw_z), .mem_data(mem_data),
    .busy(busy_z)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy got %b want 0", busy); end
    n_cmp++; if (mem_rw !== 1'b1) begin n_err++; $display("FAIL reset mem_rw got %b want 1", mem_rw); end
    n_cmp++; if (mem_address !== 32'h0) begin n_err++; $display("FAIL reset mem_address got %h want 0", mem_address); end
    n_cmp++; if ({ack0, ack1} !== 2'b00) begin n_err++; $display("FAIL reset acks got %b want 00", {ack0, ack1}); end
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle busy got %b want 0", busy); end
    n_cmp++; if ({rdata0, rdata1, mem_datao} !== 96'h0) begin n_err++; $display("FAIL idle data got %h want 0", {rdata0, rdata1, mem_datao}); end
  endtask

  task automatic test_wait0();
    addr0 = 32'h4; wdata0 = 32'h0; we0 = 1'b0; mem_data = 32'h1234; req0 = 1'b1;
    @(posedge clock); #1;
    n_cmp++; if (maddr_z !== 32'h4) begin n_err++; $display("FAIL w0 mem_address got %h want 4", maddr_z); end
    n_cmp++; if ({mrw_z, busy_z, ack0_z} !== 3'b110) begin n_err++; $display("FAIL w0 rw/busy/ack got %b want 110", {mrw_z, busy_z, ack0_z}); end
    n_cmp++; if (mdo_z !== 32'h0) begin n_err++; $display("FAIL w0 datao got %h want 0", mdo_z); end
    @(posedge clock); #1;
    n_cmp++; if ({ack0_z, ack1_z} !== 2'b10) begin n_err++; $display("FAIL w0 ack got %b want 10", {ack0_z, ack1_z}); end
    n_cmp++; if (rdata0_z !== 32'h1234) begin n_err++; $display("FAIL w0 rdata0 got %h want 1234", rdata0_z); end
    n_cmp++; if (rdata1_z !== 32'h0) begin n_err++; $display("FAIL w0 rdata1 got %h want 0", rdata1_z); end
    req0 = 1'b0;
    @(posedge clock); #1;
    n_cmp++; if ({ack0_z, busy_z} !== 2'b00) begin n_err++; $display("FAIL w0 after ack/busy got %b want 00", {ack0_z, busy_z}); end
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic test_read_p0();
    addr0 = 32'h10; we0 = 1'b0; wdata0 = 32'h0; mem_data = 32'hDEADBEEF; req0 = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i <= W; i++) begin
      n_cmp++; if ({mem_rw, busy, ack0} !== 3'b110) begin n_err++; $display("FAIL rd0 c%0d rw/busy/ack got %b want 110", i, {mem_rw, busy, ack0}); end
      n_cmp++; if (mem_address !== 32'h10) begin n_err++; $display("FAIL rd0 c%0d mem_address got %h want 10", i, mem_address); end
      @(posedge clock); #1;
    end
    n_cmp++; if ({ack0, ack1} !== 2'b10) begin n_err++; $display("FAIL rd0 ack got %b want 10", {ack0, ack1}); end
    n_cmp++; if (rdata0 !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd0 rdata0 got %h want deadbeef", rdata0); end
    n_cmp++; if (mem_address !== 32'h0) begin n_err++; $display("FAIL rd0 bus release got %h want 0", mem_address); end
    req0 = 1'b0;
    @(posedge clock); #1;
    n_cmp++; if ({ack0, busy} !== 2'b00) begin n_err++; $display("FAIL rd0 after ack/busy got %b want 00", {ack0, busy}); end
  endtask

  task automatic test_reset_mid_access();
    addr0 = 32'h30; we0 = 1'b0; req0 = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    n_cmp++; if ({busy, mem_address} !== {1'b1, 32'h30}) begin n_err++; $display("FAIL rst_mid pre busy/addr got %b/%h want 1/30", busy, mem_address); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({ack0, ack1, busy, mem_rw} !== 4'b0001) begin n_err++; $display("FAIL rst_mid ctl got %b want 0001", {ack0, ack1, busy, mem_rw}); end
    n_cmp++; if (mem_address !== 32'h0) begin n_err++; $display("FAIL rst_mid mem_address got %h want 0", mem_address); end
    n_cmp++; if (rdata0 !== 32'h0) begin n_err++; $display("FAIL rst_mid rdata0 got %h want 0", rdata0); end
    req0 = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      n_cmp++; if ({ack0, ack1} !== 2'b00) begin n_err++; $display("FAIL rst_mid c%0d late ack got %b want 00", i, {ack0, ack1}); end
    end
  endtask

  task automatic test_write_p1();
    addr1 = 32'h20; wdata1 = 32'h55AA; we1 = 1'b1; mem_data = 32'h13579BDF; req1 = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i <= W; i++) begin
      n_cmp++; if ({mem_rw, ack1} !== 2'b00) begin n_err++; $display("FAIL wr1 c%0d rw/ack got %b want 00", i, {mem_rw, ack1}); end
      n_cmp++; if ({mem_address, mem_datao} !== {32'h20, 32'h55AA}) begin n_err++; $display("FAIL wr1 c%0d addr/data got %h/%h want 20/55aa", i, mem_address, mem_datao); end
      @(posedge clock); #1;
    end
    n_cmp++; if ({ack0, ack1} !== 2'b01) begin n_err++; $display("FAIL wr1 ack got %b want 01", {ack0, ack1}); end
    n_cmp++; if (rdata1 !== 32'h0) begin n_err++; $display("FAIL wr1 rdata1 got %h want 0", rdata1); end
    n_cmp++; if ({mem_rw, mem_datao} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL wr1 release got %b/%h want 1/0", mem_rw, mem_datao); end
    req1 = 1'b0; we1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      n_cmp++; if (ack1 !== 1'b0) begin n_err++; $display("FAIL wr1 c%0d extra ack1 got %b want 0", i, ack1); end
    end
  endtask

  task automatic test_contention();
    int seen;
    int port_q[4];
    int t_q[4];
    seen = 0;
    addr0 = 32'hA0; addr1 = 32'hB0; we0 = 1'b0; we1 = 1'b0; req0 = 1'b1; req1 = 1'b1;
    do_reset();
    for (int t = 0; t < 4 * (W + 3) + W + 2 && seen < 4; t++) begin
      @(posedge clock); #1;
      n_cmp++; if ((ack0 & ack1) !== 1'b0) begin n_err++; $display("FAIL cont t%0d both acks got 1 want 0", t); end
      if (ack0 | ack1) begin port_q[seen] = ack1 ? 1 : 0; t_q[seen] = t; seen++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    n_cmp++; if (seen != 4) begin n_err++; $display("FAIL cont ack count got %0d want 4 (timeout)", seen); end
    for (int k = 0; k < seen; k++) begin
      n_cmp++; if (port_q[k] != k % 2) begin n_err++; $display("FAIL cont grant%0d got port %0d want %0d", k, port_q[k], k % 2); end
      n_cmp++; if (t_q[k] != W + 1 + k * (W + 3)) begin n_err++; $display("FAIL cont ack%0d time got %0d want %0d", k, t_q[k], W + 1 + k * (W + 3)); end
    end
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic test_req_drop();
    addr0 = 32'h40; we0 = 1'b0; mem_data = 32'hCAFEF00D; req0 = 1'b1;
    @(posedge clock); #1;
    addr1 = 32'h50; wdata1 = 32'h77; we1 = 1'b1; req1 = 1'b1;
    for (int t = 1; t <= 2 * W + 5; t++) begin
      @(posedge clock); #1;
      n_cmp++; if (ack0 !== (t == W + 1)) begin n_err++; $display("FAIL drop t%0d ack0 got %b want %b", t, ack0, t == W + 1); end
      n_cmp++; if (ack1 !== (t == 2 * W + 4)) begin n_err++; $display("FAIL drop t%0d ack1 got %b want %b", t, ack1, t == 2 * W + 4); end
      if (t <= W) begin
        n_cmp++; if (mem_address !== 32'h40) begin n_err++; $display("FAIL drop t%0d held addr got %h want 40", t, mem_address); end
      end
      if (t == W + 1) begin
        n_cmp++; if (rdata0 !== 32'hCAFEF00D) begin n_err++; $display("FAIL drop rdata0 got %h want cafef00d", rdata0); end
      end
      if (t == W + 3) begin
        n_cmp++; if ({mem_address, mem_rw} !== {32'h50, 1'b0}) begin n_err++; $display("FAIL drop next grant got %h/%b want 50/0", mem_address, mem_rw); end
      end
      if (t == 1) req0 = 1'b0;
      if (t == 2 * W + 4) req1 = 1'b0;
    end
    we1 = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] a[2], d[2], rd[2], md, exp_a, exp_d;
    logic w[2];
    logic [1:0] pat;
    logic pref, exp_rw;
    int ord[2];
    int n, k, off, o;
    req0 = 1'b0; req1 = 1'b0;
    do_reset();
    pref = 1'b0; rd[0] = '0; rd[1] = '0;
    for (int it = 0; it < 40; it++) begin
      pat = 2'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++) begin a[p] = $urandom; d[p] = $urandom; w[p] = 1'($urandom_range(0, 1)); end
      ord[0] = (pat == 2'b11) ? int'(pref) : (pat == 2'b10 ? 1 : 0);
      ord[1] = 1 - ord[0];
      n = (pat == 2'b11) ? 2 : 1;
      addr0 = a[0]; wdata0 = d[0]; we0 = w[0]; addr1 = a[1]; wdata1 = d[1]; we1 = w[1];
      req0 = pat[0]; req1 = pat[1];
      for (int t = 0; t < n * (W + 3); t++) begin
        mem_data = $urandom; md = mem_data;
        @(posedge clock); #1;
        k = t / (W + 3); off = t % (W + 3); o = ord[k];
        if (off == W + 1 && !w[o]) rd[o] = md;
        exp_a = (off <= W) ? a[o] : 32'h0;
        exp_d = (off <= W) ? d[o] : 32'h0;
        exp_rw = (off <= W) ? !w[o] : 1'b1;
        n_cmp++; if (ack0 !== (off == W + 1 && o == 0)) begin n_err++; $display("FAIL rnd i%0d t%0d ack0 got %b", it, t, ack0); end
        n_cmp++; if (ack1 !== (off == W + 1 && o == 1)) begin n_err++; $display("FAIL rnd i%0d t%0d ack1 got %b", it, t, ack1); end
        n_cmp++; if (busy !== (off <= W + 1)) begin n_err++; $display("FAIL rnd i%0d t%0d busy got %b want %b", it, t, busy, off <= W + 1); end
        n_cmp++; if (mem_address !== exp_a) begin n_err++; $display("FAIL rnd i%0d t%0d mem_address got %h want %h", it, t, mem_address, exp_a); end
        n_cmp++; if (mem_datao !== exp_d) begin n_err++; $display("FAIL rnd i%0d t%0d mem_datao got %h want %h", it, t, mem_datao, exp_d); end
        n_cmp++; if (mem_rw !== exp_rw) begin n_err++; $display("FAIL rnd i%0d t%0d mem_rw got %b want %b", it, t, mem_rw, exp_rw); end
        n_cmp++; if ({rdata0, rdata1} !== {rd[0], rd[1]}) begin n_err++; $display("FAIL rnd i%0d t%0d rdata got %h/%h want %h/%h", it, t, rdata0, rdata1, rd[0], rd[1]); end
        if (off == W + 1 && o == 0) req0 = 1'b0;
        if (off == W + 1 && o == 1) req1 = 1'b0;
      end
      pref = (ord[n - 1] == 0);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_data = '0;
    test_reset();
    test_wait0();
    test_read_p0();
    test_reset_mid_access();
    test_write_p1();
    test_contention();
    test_req_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
